// File: rtl/eth_tx_framer.sv
// eth_tx_framer: byte-wide Ethernet TX framer (preamble, SFD, payload, pad, FCS, IFG).
// Define ETH_TX_PAD_EN to pad short frames with zeros up to MIN_FRAME bytes.
module eth_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        underrun,
  output logic        busy,
  output logic        crc_rst,
  output logic        crc_en,
  output logic [7:0]  crc_data,
  input  logic [31:0] crc_in
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
`ifdef ETH_TX_PAD_EN
    PAD,
`endif
    FCS,
    IFG
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  ph_q, ph_d;
  logic [10:0] len_q, len_d;
  logic [10:0] len_inc;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d;
  logic        underrun_q, underrun_d;
  logic [7:0]  fcs_b;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign len_inc = (len_q == '1) ? len_q : len_q + 11'd1;

  // FCS goes out MSB slice of the engine state first, one byte per cycle
  always_comb begin
    fcs_b = crc_in[31:24];
    unique case (ph_q[1:0])
      2'd0: fcs_b = crc_in[31:24];
      2'd1: fcs_b = crc_in[23:16];
      2'd2: fcs_b = crc_in[15:8];
      2'd3: fcs_b = crc_in[7:0];
      default: fcs_b = crc_in[31:24];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    len_d      = len_q;
    tx_data_d  = 8'h00;
    tx_en_d    = 1'b0;
    underrun_d = 1'b0;
    s_ready    = 1'b0;
    crc_en     = 1'b0;
    crc_data   = 8'h00;
    crc_rst    = rst;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (s_valid) begin
            state_d = PREAMBLE;
            ph_d    = '0;
          end
        end
        PREAMBLE: begin
          tx_data_d = 8'h55;
          tx_en_d   = 1'b1;
          crc_rst   = (ph_q == 8'd0);
          if (ph_q == 8'd6) begin
            state_d = SFD;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + 8'd1;
          end
        end
        SFD: begin
          tx_data_d = 8'hD5;
          tx_en_d   = 1'b1;
          len_d     = '0;
          state_d   = PAYLOAD;
        end
        PAYLOAD: begin
          s_ready = 1'b1;
          if (s_valid) begin
            tx_data_d = s_data;
            tx_en_d   = 1'b1;
            crc_en    = 1'b1;
            crc_data  = bitrev8(s_data);
            len_d     = len_inc;
            if (s_last) begin
              state_d = FCS;
              ph_d    = '0;
`ifdef ETH_TX_PAD_EN
              if ({1'b0, len_q} + 12'd1 < 12'(MIN_FRAME))
                state_d = PAD;
`endif
            end
          end else begin
            // source starved mid-frame: drop the frame, no FCS
            underrun_d = 1'b1;
            state_d    = IFG;
            ph_d       = '0;
          end
        end
`ifdef ETH_TX_PAD_EN
        PAD: begin
          tx_data_d = 8'h00;
          tx_en_d   = 1'b1;
          crc_en    = 1'b1;
          len_d     = len_inc;
          if ({1'b0, len_q} + 12'd1 >= 12'(MIN_FRAME)) begin
            state_d = FCS;
            ph_d    = '0;
          end
        end
`endif
        FCS: begin
          tx_data_d = ~bitrev8(fcs_b);
          tx_en_d   = 1'b1;
          if (ph_q == 8'd3) begin
            state_d = IFG;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + 8'd1;
          end
        end
        IFG: begin
          if (ph_q == 8'(IFG_BYTES - 1)) begin
            // skip IDLE so back-to-back gap is exactly IFG_BYTES
            state_d = s_valid ? PREAMBLE : IDLE;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      len_q      <= '0;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      len_q      <= len_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
      underrun_q <= underrun_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_en    = tx_en_q;
  assign underrun = underrun_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: random-payload bench for eth_tx_framer with a CRC engine
// model and a reflected-CRC frame reference.
module tb_eth_tx_framer;
  localparam int IFG  = 12;
  localparam int MINF = 60;
`ifdef ETH_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        underrun;
  logic        busy;
  logic        crc_rst;
  logic        crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc_in;

  int n_chk = 0;
  int n_fail = 0;

  eth_tx_framer #(.IFG_BYTES(IFG), .MIN_FRAME(MINF)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .tx_data(tx_data), .tx_en(tx_en), .underrun(underrun), .busy(busy),
    .crc_rst(crc_rst), .crc_en(crc_en), .crc_data(crc_data), .crc_in(crc_in)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  // CRC engine the framer drives
  logic [31:0] eng_q;
  always @(posedge clk) begin
    if (crc_rst) eng_q <= 32'hFFFFFFFF;
    else if (crc_en) eng_q <= crc_step(eng_q, crc_data);
  end
  assign crc_in = eng_q;

  // wire monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cap[$];
  int gaps[$];
  int rises[$];
  int zero_run = 0;
  bit seen = 1'b0;
  bit prev_en = 1'b0;

  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      if (!prev_en && seen) gaps.push_back(zero_run);
      if (!prev_en) rises.push_back(cyc);
      cap.push_back(tx_data);
      zero_run = 0;
      seen = 1'b1;
      prev_en = 1'b1;
    end else begin
      zero_run++;
      prev_en = 1'b0;
    end
  end

  logic [7:0] sd_q[$];
  bit         sl_q[$];
  logic [7:0] exp_q[$];

  task automatic clear_mon();
    cap.delete(); gaps.delete(); rises.delete();
    exp_q.delete(); sd_q.delete(); sl_q.delete();
    seen = 1'b0; zero_run = 0;
  endtask

  // reference frame: preamble, SFD, payload, zero pad, reflected CRC-32 FCS
  task automatic add_frame(input int n, input bit pattern);
    logic [7:0] b;
    logic [31:0] c;
    int tot;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    tot = (PAD_EN && n < MINF) ? MINF : n;
    for (int i = 0; i < tot; i++) begin
      if (i < n) begin
        b = pattern ? 8'(i) : 8'($urandom_range(0, 255));
        sd_q.push_back(b);
        sl_q.push_back(i == n - 1);
      end else begin
        b = 8'h00;
      end
      exp_q.push_back(b);
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic drive_stream(output bit ok);
    int budget;
    bit fire;
    budget = 300 + 3 * sd_q.size();
    ok = 1'b1;
    while (sd_q.size() > 0) begin
      s_valid = 1'b1; s_data = sd_q[0]; s_last = sl_q[0];
      @(negedge clk); fire = s_ready;
      @(posedge clk); #1;
      if (fire) begin
        void'(sd_q.pop_front());
        void'(sl_q.pop_front());
      end
      budget--;
      if (budget == 0) begin ok = 1'b0; break; end
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  function automatic int first_diff();
    int n;
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (cap[i] !== exp_q[i]) return i;
    return (cap.size() == exp_q.size()) ? -1 : n;
  endfunction

  function automatic logic [31:0] residue(input int from, input int to);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    if (to > cap.size()) return 32'h0;
    for (int i = from; i < to; i++) r = crc_step(r, bitrev8(cap[i]));
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (tx_en !== 1'b0) begin n_fail++; $display("FAIL rst_tx_en: got %b want 0", tx_en); end
    n_chk++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    n_chk++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    n_chk++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (crc_en !== 1'b0) begin n_fail++; $display("FAIL rst_crc_en: got %b want 0", crc_en); end
    n_chk++; if (crc_data !== 8'h00) begin n_fail++; $display("FAIL rst_crc_data: got %h want 00", crc_data); end
    n_chk++; if (crc_rst !== 1'b1) begin n_fail++; $display("FAIL rst_crc_rst: got %b want 1", crc_rst); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (crc_rst !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_rst: crc_rst=%b busy=%b want 0/0", crc_rst, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_min_frame();
    bit ok1, ok2;
    int t0, d;
    clear_mon();
    add_frame(60, 1'b1);
    t0 = cyc;
    drive_stream(ok1);
    wait_idle(ok2);
    n_chk++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL min_timeout: drive=%b idle=%b want 1/1", ok1, ok2); end
    n_chk++; if (rises.size() < 1 || rises[0] - t0 != 2) begin
      n_fail++; $display("FAIL min_latency: got %0d want 2", rises.size() ? rises[0] - t0 : -1);
    end
    n_chk++; if (cap.size() != 72) begin n_fail++; $display("FAIL min_len: got %0d want 72", cap.size()); end
    d = first_diff();
    n_chk++; if (d != -1) begin n_fail++; $display("FAIL min_data: first bad byte %0d want -1", d); end
    n_chk++; if (residue(8, 72) !== 32'hC704DD7B) begin
      n_fail++; $display("FAIL min_residue: got %h want c704dd7b", residue(8, 72));
    end
  endtask

  task automatic test_short_frame();
    bit ok1, ok2;
    int d, want;
    want = PAD_EN ? 72 : 26;
    clear_mon();
    add_frame(14, 1'b0);
    drive_stream(ok1);
    wait_idle(ok2);
    n_chk++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL short_timeout: drive=%b idle=%b want 1/1", ok1, ok2); end
    n_chk++; if (cap.size() != want) begin n_fail++; $display("FAIL short_len: got %0d want %0d", cap.size(), want); end
    d = first_diff();
    n_chk++; if (d != -1) begin n_fail++; $display("FAIL short_data: first bad byte %0d want -1", d); end
    n_chk++; if (residue(8, want) !== 32'hC704DD7B) begin
      n_fail++; $display("FAIL short_residue: got %h want c704dd7b", residue(8, want));
    end
  endtask

  task automatic test_random_frames();
    bit ok1, ok2;
    int n, d, want;
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, 130);
      want = 8 + ((PAD_EN && n < MINF) ? MINF : n) + 4;
      clear_mon();
      add_frame(n, 1'b0);
      drive_stream(ok1);
      wait_idle(ok2);
      n_chk++; if (cap.size() != want || !ok1 || !ok2) begin
        n_fail++; $display("FAIL rnd_len n=%0d: got %0d want %0d", n, cap.size(), want);
      end
      d = first_diff();
      n_chk++; if (d != -1) begin n_fail++; $display("FAIL rnd_data n=%0d: first bad byte %0d want -1", n, d); end
      n_chk++; if (residue(8, want) !== 32'hC704DD7B) begin
        n_fail++; $display("FAIL rnd_residue n=%0d: got %h want c704dd7b", n, residue(8, want));
      end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    logic [7:0] lastb;
    clear_mon();
    for (int i = 0; i < 20; i++) begin
      sd_q.push_back(8'($urandom_range(0, 255)));
      sl_q.push_back(1'b0);
    end
    lastb = sd_q[19];
    drive_stream(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL und_timeout: got 0 want 1"); end
    @(negedge clk);
    n_chk++; if (tx_en !== 1'b1 || tx_data !== lastb) begin
      n_fail++; $display("FAIL und_last_byte: got en=%b %h want 1 %h", tx_en, tx_data, lastb);
    end
    @(negedge clk);
    n_chk++; if (tx_en !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL und_tx_off: got en=%b %h want 0 00", tx_en, tx_data);
    end
    n_chk++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL und_pulse: got %b want 1", underrun); end
    n_chk++; if (s_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL und_gap0: ready=%b busy=%b want 0/1", s_ready, busy);
    end
    for (int i = 1; i < IFG; i++) begin
      @(negedge clk);
      n_chk++; if (s_ready !== 1'b0 || busy !== 1'b1 || underrun !== 1'b0 || tx_en !== 1'b0) begin
        n_fail++;
        $display("FAIL und_gap%0d: ready=%b busy=%b und=%b en=%b want 0/1/0/0", i, s_ready, busy, underrun, tx_en);
      end
    end
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL und_idle: busy=%b want 0", busy); end
    n_chk++; if (cap.size() != 28) begin n_fail++; $display("FAIL und_len: got %0d want 28", cap.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    bit ok1, ok2;
    int d;
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      sd_q.push_back(8'($urandom_range(0, 255)));
      sl_q.push_back(1'b0);
    end
    drive_stream(ok1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (tx_en !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL mrst_tx: got en=%b %h want 0 00", tx_en, tx_data);
    end
    n_chk++; if (s_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mrst_state: ready=%b busy=%b want 0/0", s_ready, busy);
    end
    n_chk++; if (crc_rst !== 1'b1 || underrun !== 1'b0) begin
      n_fail++; $display("FAIL mrst_crc: crc_rst=%b und=%b want 1/0", crc_rst, underrun);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_chk++; if (cap.size() != 18 || !ok1) begin
      n_fail++; $display("FAIL mrst_no_fcs: got %0d bytes want 18", cap.size());
    end
    clear_mon();
    add_frame(14, 1'b0);
    drive_stream(ok1);
    wait_idle(ok2);
    d = first_diff();
    n_chk++; if (d != -1 || !ok1 || !ok2) begin
      n_fail++; $display("FAIL mrst_next_frame: first bad byte %0d want -1", d);
    end
    n_chk++; if (residue(8, cap.size()) !== 32'hC704DD7B) begin
      n_fail++; $display("FAIL mrst_residue: got %h want c704dd7b", residue(8, cap.size()));
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int d;
    clear_mon();
    add_frame(64, 1'b0);
    add_frame(64, 1'b0);
    drive_stream(ok1);
    wait_idle(ok2);
    n_chk++; if (cap.size() != 152 || !ok1 || !ok2) begin
      n_fail++; $display("FAIL b2b_len: got %0d want 152", cap.size());
    end
    d = first_diff();
    n_chk++; if (d != -1) begin n_fail++; $display("FAIL b2b_data: first bad byte %0d want -1", d); end
    n_chk++; if (gaps.size() != 1 || gaps[0] != IFG) begin
      n_fail++; $display("FAIL b2b_gap: got %0d gaps, first %0d want 1 gap of %0d",
                         gaps.size(), gaps.size() ? gaps[0] : -1, IFG);
    end
    n_chk++; if (residue(8, 76) !== 32'hC704DD7B) begin
      n_fail++; $display("FAIL b2b_residue1: got %h want c704dd7b", residue(8, 76));
    end
    n_chk++; if (residue(84, 152) !== 32'hC704DD7B) begin
      n_fail++; $display("FAIL b2b_residue2: got %h want c704dd7b", residue(84, 152));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_min_frame();
    test_short_frame();
    test_random_frames();
    test_underrun();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
